// File: rtl/ysyx_040978_div_ctrl_pkg.sv
// Shared encodings and helpers for the divide-unit controller and its operand prep.
// Result formatting lives here so the bypass and divider paths format identically.
package ysyx_040978_div_ctrl_pkg;

  localparam int XLEN = 64;
  localparam int WLEN = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // W results are always sign-extended from bit 31, even for the unsigned variants.
  function automatic logic [XLEN-1:0] fmt_result(input logic [1:0]      op,
                                                 input logic            word,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] rem);
    logic [XLEN-1:0] sel;
    sel = op_is_rem(op) ? rem : quo;
    if (word) sel = {{(XLEN-WLEN){sel[WLEN-1]}}, sel[WLEN-1:0]};
    return sel;
  endfunction

endpackage

// File: rtl/ysyx_040978_div_prep.sv
// Combinational operand preparation: W-variant extension plus detection of the two
// cases the controller answers without the divider (divide-by-zero, signed overflow).
module ysyx_040978_div_prep
  import ysyx_040978_div_ctrl_pkg::*;
(
  input  logic [1:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic [XLEN-1:0] o_dividend,
  output logic [XLEN-1:0] o_divisor,
  output logic            o_signed,
  output logic            o_div_zero,
  output logic            o_overflow
);

  logic            w_signed;
  logic [XLEN-1:0] w_int_min;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic            word,
                                             input logic            sgn);
    if (!word) return v;
    if (sgn)   return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
    return {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]};
  endfunction

  assign w_signed   = op_is_signed(i_op);
  assign o_signed   = w_signed;
  assign o_dividend = extend(i_src1, i_word, w_signed);
  assign o_divisor  = extend(i_src2, i_word, w_signed);

  // Most-negative value of the op width, as it looks after sign extension.
  assign w_int_min  = i_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                             : {1'b1, {(XLEN-1){1'b0}}};

  assign o_div_zero = (o_divisor == '0);
  assign o_overflow = w_signed && (o_divisor == '1) && (o_dividend == w_int_min);

endmodule

// File: rtl/ysyx_040978_div_ctrl.sv
// Divide-unit sequencer between the execute stage and a 64-cycle iterative divider.
//   state | meaning
//   IDLE  | ready to accept a new op
//   ISSUE | one-cycle start pulse to the divider
//   WAIT  | divider busy, result pending
//   DRAIN | op killed by flush; absorb and drop the divider result
//   RESP  | result held until consumed
module ysyx_040978_div_ctrl
  import ysyx_040978_div_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_req_op,
  input  logic            i_req_word,
  input  logic [XLEN-1:0] i_req_src1,
  input  logic [XLEN-1:0] i_req_src2,
  input  logic            i_flush,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [XLEN-1:0] o_resp_data,
  output logic            o_div_in_valid,
  output logic            o_div_signed,
  output logic [XLEN-1:0] o_div_dividend,
  output logic [XLEN-1:0] o_div_divisor,
  input  logic            i_div_out_valid,
  input  logic [XLEN-1:0] i_div_quotient,
  input  logic [XLEN-1:0] i_div_remainder
);

  logic [2:0]      r_state;
  logic [1:0]      r_op;
  logic            r_word;
  logic            r_signed;
  logic [XLEN-1:0] r_dividend;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_resp_data;

  logic [XLEN-1:0] w_dividend;
  logic [XLEN-1:0] w_divisor;
  logic            w_signed;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_accept;
  logic [XLEN-1:0] w_byp_quo;
  logic [XLEN-1:0] w_byp_rem;

  ysyx_040978_div_prep u_prep (
    .i_op       (i_req_op),
    .i_word     (i_req_word),
    .i_src1     (i_req_src1),
    .i_src2     (i_req_src2),
    .o_dividend (w_dividend),
    .o_divisor  (w_divisor),
    .o_signed   (w_signed),
    .o_div_zero (w_div_zero),
    .o_overflow (w_overflow)
  );

  assign o_req_ready    = (r_state == S_IDLE) && !i_flush;
  assign w_accept       = i_req_valid && o_req_ready;
  assign o_div_in_valid = (r_state == S_ISSUE) && !i_flush;
  assign o_resp_valid   = (r_state == S_RESP);
  assign o_resp_data    = r_resp_data;
  assign o_div_signed   = r_signed;
  assign o_div_dividend = r_dividend;
  assign o_div_divisor  = r_divisor;

  // Zero divisor: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
  assign w_byp_quo = w_div_zero ? '1 : w_dividend;
  assign w_byp_rem = w_div_zero ? w_dividend : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_DIV;
      r_word      <= 1'b0;
      r_signed    <= 1'b0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= i_req_op;
            r_word     <= i_req_word;
            r_signed   <= w_signed;
            r_dividend <= w_dividend;
            r_divisor  <= w_divisor;
            if (w_div_zero || w_overflow) begin
              r_resp_data <= fmt_result(i_req_op, i_req_word, w_byp_quo, w_byp_rem);
              r_state     <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: r_state <= i_flush ? S_IDLE : S_WAIT;
        S_WAIT: begin
          if (i_div_out_valid) begin
            if (i_flush) begin
              r_state <= S_IDLE;
            end else begin
              r_resp_data <= fmt_result(r_op, r_word, i_div_quotient, i_div_remainder);
              r_state     <= S_RESP;
            end
          end else if (i_flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: if (i_div_out_valid) r_state <= S_IDLE;
        S_RESP:  if (i_flush || i_resp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_040978_div_ctrl.md
YSYX_040978_DIV_CTRL -- requirements
Module: ysyx_040978_div_ctrl

Interface
REQ-001 SHALL have: clock  in  1  system clock.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: req_valid  in  1  execute stage presents a divide op.
REQ-004 SHALL have: req_ready  out  1  controller accepts op this cycle.
REQ-005 SHALL have: req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have: req_word  in  1  RV64 W-variant (32-bit op).
REQ-007 SHALL have: req_src1 / req_src2  in  64 each  dividend / divisor.
REQ-008 SHALL have: flush  in  1  pipeline kill; discard in-flight op.
REQ-009 SHALL have: resp_valid  out  1; resp_ready  in  1; resp_data  out  64  final rd value.
REQ-010 SHALL have: div_in_valid  out  1; div_signed  out  1; div_dividend / div_divisor  out  64  to 64-cycle iterative divider.
REQ-011 SHALL have: div_out_valid  in  1  one-cycle pulse; div_quotient / div_remainder  in  64.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, DRAIN, RESP; req_ready = (state==IDLE) && !flush.
REQ-013 SHALL accept on req_valid && req_ready, registering op, word flag and prepared operands.
REQ-014 Operand prep SHALL: W signed -> sign-extend src[31:0]; W unsigned -> zero-extend src[31:0]; non-W -> pass through.
REQ-015 div_signed SHALL be 1 for DIV/REM, 0 for DIVU/REMU, stable from ISSUE through WAIT.
REQ-016 Divide-by-zero (prepared divisor == 0) SHALL bypass the divider: IDLE -> RESP, quotient = all ones, remainder = prepared dividend.
REQ-017 Signed overflow (dividend = most-negative of the op width, divisor = -1) SHALL bypass: quotient = prepared dividend, remainder = 0.
REQ-018 Otherwise IDLE -> ISSUE; in ISSUE div_in_valid SHALL be 1 for exactly one cycle, then ISSUE -> WAIT.
REQ-019 div_in_valid SHALL never assert outside ISSUE, so the divider is never issued while busy.
REQ-020 In WAIT, on div_out_valid the selected result SHALL be registered and state -> RESP; resp_valid rises the next cycle.
REQ-021 Result select: REM/REMU -> remainder, else quotient; if word, resp_data = sign-extension of bit 31 (for signed and unsigned W ops alike).
REQ-022 In RESP resp_valid SHALL be 1 and resp_data stable until resp_ready; handshake -> IDLE, so the next accept is earliest one cycle later.
REQ-023 flush in ISSUE SHALL suppress div_in_valid and go IDLE.
REQ-024 flush in WAIT SHALL go DRAIN (divider cannot abort); DRAIN holds req_ready=0 until div_out_valid, discards it, goes IDLE.
REQ-025 flush in WAIT coincident with div_out_valid SHALL discard the result and go IDLE directly.
REQ-026 flush in RESP SHALL drop resp_valid next cycle and go IDLE, even if resp_ready is high that cycle (no response counted).
REQ-027 flush in IDLE SHALL block acceptance that cycle.
REQ-028 A div_out_valid received in IDLE or RESP SHALL be ignored.

Reset
REQ-029 Reset SHALL force IDLE; resp_valid, div_in_valid, div_signed, resp_data, div_dividend, div_divisor all 0; req_ready = 1 the first cycle after reset deasserts.
REQ-030 Reset mid-operation SHALL abandon the op with no response; divider shares the same reset.

Structure
REQ-031 Shared package SHALL hold the state encoding, req_op encodings, and XLEN=64 / WLEN=32 constants.
REQ-032 One sub-module SHALL be ysyx_040978_div_prep: combinational operand extension plus div-by-zero/overflow detection; divider instantiated at the EXU level, not inside.

Verification
REQ-033 DIV src1=-7, src2=2 -> one div_in_valid pulse, div_signed=1, resp_data=0xFFFFFFFFFFFFFFFD.
REQ-034 REMUW src1=0x00000000_FFFFFFFF, src2=0x10 -> div_dividend=0xFFFFFFFF, resp_data=0x000000000000000F.
REQ-035 DIVU src2=0 src1=5 -> no div_in_valid, resp_valid 1 cycle after accept, data=all ones; REM same operands -> 5.
REQ-036 DIVW src1=0x80000000, src2=0xFFFFFFFF -> no div_in_valid, resp_data=0xFFFFFFFF80000000; REMW -> 0.
REQ-037 Flush 10 cycles into WAIT, req_valid held high -> req_ready 0 until div_out_valid, no resp_valid, next op accepted cycle after.
REQ-038 resp_ready low 5 cycles in RESP -> resp_valid and resp_data constant; reset asserted in WAIT -> IDLE, no response.
